// File: rtl/prod_acc_pkg.sv
// Shared types for the multiplier/product-accumulator pair: operand signedness
// encoding and the accumulator FSM states.
package prod_acc_pkg;

    typedef enum logic [1:0] {
        TC_UU = 2'b00,
        TC_SU = 2'b01,
        TC_US = 2'b10,
        TC_SS = 2'b11
    } tc_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } acc_state_e;

    // Any mode with at least one signed operand yields a signed product.
    function automatic logic is_signed_mode(input tc_mode_e mode);
        return mode != TC_UU;
    endfunction

endpackage

// File: rtl/prod_acc_sat_add.sv
// Saturating ACw-bit adder: unsigned clamp to [0, 2^ACw-1] or two's complement
// clamp to the signed range, with a flag when clamping occurred.
module sat_add #(
    parameter int ACw = 16
) (
    input  logic [ACw-1:0] a_i,
    input  logic [ACw-1:0] b_i,
    input  logic           signed_i,
    output logic [ACw-1:0] sum_o,
    output logic           sat_o
);

    logic [ACw:0] raw_sum;

    assign raw_sum = {1'b0, a_i} + {1'b0, b_i};

    always_comb begin
        sum_o = raw_sum[ACw-1:0];
        sat_o = 1'b0;
        if (signed_i) begin
            // Signed overflow: like-signed operands producing an opposite-signed sum.
            if ((a_i[ACw-1] == b_i[ACw-1]) && (raw_sum[ACw-1] != a_i[ACw-1])) begin
                sat_o = 1'b1;
                sum_o = a_i[ACw-1] ? {1'b1, {(ACw-1){1'b0}}} : {1'b0, {(ACw-1){1'b1}}};
            end
        end else if (raw_sum[ACw]) begin
            sat_o = 1'b1;
            sum_o = '1;
        end
    end

endmodule

// File: rtl/prod_acc.sv
// Groups multiplier products into saturating sums of a programmable length and
// presents each sum through a one-entry valid/ready result buffer.
module prod_acc
    import prod_acc_pkg::*;
#(
    parameter int PDw = 12,
    parameter int ACw = 16,
    parameter int CNw = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [1:0]     tc_mode_i,
    input  logic [CNw-1:0] len_i,
    input  logic           prod_valid_i,
    input  logic [PDw-1:0] prod_i,
    input  logic           flush_i,
    input  logic           clr_err_i,
    output logic           acc_valid_o,
    input  logic           acc_ready_i,
    output logic [ACw-1:0] acc_o,
    output logic           sat_o,
    output logic           stall_o,
    output logic           err_drop_o
);

    acc_state_e     state_q, state_d;
    tc_mode_e       mode_q, mode_d;
    logic [CNw-1:0] len_q, len_d;
    logic [CNw-1:0] cnt_q, cnt_d;
    logic [ACw-1:0] acc_q, acc_d;
    logic           gsat_q, gsat_d;
    logic           res_valid_q, res_valid_d;
    logic [ACw-1:0] res_acc_q, res_acc_d;
    logic           res_sat_q, res_sat_d;
    logic           err_q, err_d;

    logic           in_idle;
    logic           add_signed;
    logic [ACw-1:0] prod_ext;
    logic [ACw-1:0] add_a;
    logic [ACw-1:0] add_sum;
    logic           add_sat;
    logic [CNw-1:0] len_eff;
    logic [CNw-1:0] cnt_next;
    logic           done;
    logic           pop;
    logic           drop;

    // The first product of a group uses the live mode; later ones the latched mode.
    assign in_idle    = (state_q == ST_IDLE);
    assign add_signed = is_signed_mode(in_idle ? tc_mode_e'(tc_mode_i) : mode_q);
    assign prod_ext   = add_signed ? ACw'($signed(prod_i)) : ACw'(prod_i);
    assign add_a      = in_idle ? '0 : acc_q;
    assign len_eff    = (len_i == '0) ? CNw'(1) : len_i;
    assign cnt_next   = cnt_q + CNw'(1);
    assign pop        = res_valid_q & acc_ready_i;

    sat_add #(.ACw(ACw)) u_sat_add (
        .a_i      (add_a),
        .b_i      (prod_ext),
        .signed_i (add_signed),
        .sum_o    (add_sum),
        .sat_o    (add_sat)
    );

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        state_d     = state_q;
        mode_d      = mode_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        gsat_d      = gsat_q;
        res_valid_d = res_valid_q;
        res_acc_d   = res_acc_q;
        res_sat_d   = res_sat_q;
        done        = 1'b0;
        drop        = 1'b0;

        if (flush_i) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            gsat_d  = 1'b0;
        end else if (prod_valid_i) begin
            if (in_idle) begin
                mode_d = tc_mode_e'(tc_mode_i);
                len_d  = len_eff;
                done   = (len_eff == CNw'(1));
                if (!done) begin
                    state_d = ST_ACC;
                    acc_d   = add_sum;
                    cnt_d   = CNw'(1);
                    gsat_d  = 1'b0;
                end
            end else begin
                done   = (cnt_next == len_q);
                acc_d  = add_sum;
                cnt_d  = cnt_next;
                gsat_d = gsat_q | add_sat;
            end
            if (done) begin
                state_d = ST_IDLE;
                acc_d   = '0;
                cnt_d   = '0;
                gsat_d  = 1'b0;
            end
        end

        // A finished group loads if the buffer is empty or draining this cycle.
        if (done && (!res_valid_q || pop)) begin
            res_valid_d = 1'b1;
            res_acc_d   = add_sum;
            res_sat_d   = gsat_q | add_sat;
        end else begin
            drop = done;
            if (pop) begin
                res_valid_d = 1'b0;
            end
        end

        err_d = drop | (err_q & ~clr_err_i);
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (rst_i) begin
            state_q     <= ST_IDLE;
            mode_q      <= TC_UU;
            len_q       <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            gsat_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_acc_q   <= '0;
            res_sat_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            gsat_q      <= gsat_d;
            res_valid_q <= res_valid_d;
            res_acc_q   <= res_acc_d;
            res_sat_q   <= res_sat_d;
            err_q       <= err_d;
        end
    end

    assign acc_valid_o = res_valid_q;
    assign acc_o       = res_acc_q;
    assign sat_o       = res_sat_q;
    assign err_drop_o  = err_q;
    assign stall_o     = res_valid_q & ~acc_ready_i;

endmodule

// File: tb/tb_prod_acc.sv
// Self-checking bench for prod_acc: directed corner cases plus randomized groups
// compared against an integer-arithmetic reference of the group sum.
module tb_prod_acc;

    localparam int PDW = 12;
    localparam int ACW = 16;
    localparam int CNW = 8;

    logic           clk_i = 1'b0;
    logic           rst_i = 1'b1;
    logic [1:0]     tc_mode_i = 2'b00;
    logic [CNW-1:0] len_i = '0;
    logic           prod_valid_i = 1'b0;
    logic [PDW-1:0] prod_i = '0;
    logic           flush_i = 1'b0;
    logic           clr_err_i = 1'b0;
    logic           acc_ready_i = 1'b1;
    logic           acc_valid_o;
    logic [ACW-1:0] acc_o;
    logic           sat_o;
    logic           stall_o;
    logic           err_drop_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    prod_acc #(.PDw(PDW), .ACw(ACW), .CNw(CNW)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .tc_mode_i    (tc_mode_i),
        .len_i        (len_i),
        .prod_valid_i (prod_valid_i),
        .prod_i       (prod_i),
        .flush_i      (flush_i),
        .clr_err_i    (clr_err_i),
        .acc_valid_o  (acc_valid_o),
        .acc_ready_i  (acc_ready_i),
        .acc_o        (acc_o),
        .sat_o        (sat_o),
        .stall_o      (stall_o),
        .err_drop_o   (err_drop_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Group sum with clamping after every addition, in plain integer arithmetic.
    function automatic void ref_group(input bit sgn, input logic [PDW-1:0] prods[$],
                                      output logic [ACW-1:0] acc, output bit sat);
        longint s  = 0;
        longint lo = sgn ? -(longint'(1) << (ACW - 1)) : 0;
        longint hi = sgn ? (longint'(1) << (ACW - 1)) - 1 : (longint'(1) << ACW) - 1;
        sat = 1'b0;
        foreach (prods[i]) begin
            s += sgn ? longint'($signed(prods[i])) : longint'(prods[i]);
            if (s > hi) begin
                s   = hi;
                sat = 1'b1;
            end else if (s < lo) begin
                s   = lo;
                sat = 1'b1;
            end
        end
        acc = ACW'(s);
    endfunction

    task automatic send(input logic [PDW-1:0] p);
        prod_valid_i = 1'b1;
        prod_i       = p;
        step();
        prod_valid_i = 1'b0;
    endtask

    task automatic run_group(input string tag, input logic [1:0] mode, input int len,
                             input logic [PDW-1:0] prods[$], input bit jitter);
        logic [ACW-1:0] e_acc;
        bit             e_sat;
        tc_mode_i = mode;
        len_i     = CNW'(len);
        foreach (prods[i]) begin
            send(prods[i]);
            if (i < prods.size() - 1) begin
                if (acc_ready_i) check({tag, "_early_valid"}, 32'(acc_valid_o), 32'd0);
                if (jitter) begin
                    tc_mode_i = 2'($urandom);
                    len_i     = CNW'($urandom);
                    repeat ($urandom_range(0, 2)) step();
                end
            end
        end
        ref_group(mode != 2'b00, prods, e_acc, e_sat);
        check({tag, "_valid"}, 32'(acc_valid_o), 32'd1);
        check({tag, "_acc"}, 32'(acc_o), 32'(e_acc));
        check({tag, "_sat"}, 32'(sat_o), 32'(e_sat));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        logic [PDW-1:0] q[$];
        int             len;
        logic [1:0]     mode;

        step();
        step();
        check("rst_valid", 32'(acc_valid_o), 32'd0);
        check("rst_acc", 32'(acc_o), 32'd0);
        check("rst_sat", 32'(sat_o), 32'd0);
        check("rst_err", 32'(err_drop_o), 32'd0);
        check("rst_stall", 32'(stall_o), 32'd0);
        rst_i = 1'b0;
        step();

        q = {12'h010, 12'h020, 12'h030};
        run_group("basic_uu", 2'b00, 3, q, 1'b0);
        step();

        q = {12'hFFF, 12'h800};
        run_group("basic_ss", 2'b11, 2, q, 1'b0);
        step();

        q = {};
        for (int i = 0; i < 32; i++) q.push_back(12'hFFF);
        run_group("sat_uu", 2'b00, 32, q, 1'b0);
        step();

        q = {};
        for (int i = 0; i < 20; i++) q.push_back(12'h800);
        run_group("sat_ss", 2'b11, 20, q, 1'b0);
        step();

        q = {12'h7FF};
        run_group("len0", 2'b11, 0, q, 1'b0);
        step();

        q = {12'hFFF, 12'hFFF};
        run_group("midchg", 2'b00, 2, q, 1'b1);
        step();

        // Backpressure: second result is dropped, the first is held.
        acc_ready_i = 1'b0;
        q = {12'h005};
        run_group("hold_a", 2'b00, 1, q, 1'b0);
        check("hold_stall", 32'(stall_o), 32'd1);
        tc_mode_i = 2'b00;
        len_i     = CNW'(1);
        send(12'h007);
        check("drop_acc", 32'(acc_o), 32'h0005);
        check("drop_err", 32'(err_drop_o), 32'd1);
        check("drop_stall", 32'(stall_o), 32'd1);
        clr_err_i = 1'b1;
        send(12'h009);
        check("setclr_err", 32'(err_drop_o), 32'd1);
        step();
        clr_err_i = 1'b0;
        check("clr_err", 32'(err_drop_o), 32'd0);
        check("clr_acc", 32'(acc_o), 32'h0005);
        acc_ready_i = 1'b1;
        #1;
        check("stall_comb", 32'(stall_o), 32'd0);
        step();
        check("pop_valid", 32'(acc_valid_o), 32'd0);

        // Back-to-back single-product groups with the buffer draining each cycle.
        tc_mode_i = 2'b00;
        len_i     = CNW'(1);
        for (int v = 1; v <= 3; v++) begin
            send(PDW'(v));
            check("b2b_valid", 32'(acc_valid_o), 32'd1);
            check("b2b_acc", 32'(acc_o), 32'(v));
        end
        check("b2b_err", 32'(err_drop_o), 32'd0);
        step();

        // Flush mid-group leaves a held result alone and drops its own product.
        acc_ready_i = 1'b0;
        send(12'h033);
        len_i = CNW'(4);
        send(12'h005);
        send(12'h005);
        flush_i = 1'b1;
        send(12'h100);
        flush_i = 1'b0;
        check("flush_keep_valid", 32'(acc_valid_o), 32'd1);
        check("flush_keep_acc", 32'(acc_o), 32'h0033);
        acc_ready_i = 1'b1;
        step();
        q = {12'h001, 12'h001, 12'h001, 12'h001};
        run_group("flush", 2'b00, 4, q, 1'b0);
        step();

        // Reset with both a held result and a group in progress.
        acc_ready_i = 1'b0;
        len_i = CNW'(1);
        send(12'h009);
        len_i = CNW'(4);
        send(12'h002);
        send(12'h002);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("mrst_valid", 32'(acc_valid_o), 32'd0);
        check("mrst_acc", 32'(acc_o), 32'd0);
        check("mrst_sat", 32'(sat_o), 32'd0);
        check("mrst_err", 32'(err_drop_o), 32'd0);
        check("mrst_stall", 32'(stall_o), 32'd0);
        send(12'h002);
        send(12'h002);
        check("mrst_noresult", 32'(acc_valid_o), 32'd0);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        acc_ready_i = 1'b1;
        step();

        for (int g = 0; g < 40; g++) begin
            mode = 2'($urandom);
            len  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(16, 30))
                                               : int'($urandom_range(0, 6));
            q = {};
            for (int i = 0; i < ((len == 0) ? 1 : len); i++) begin
                case ($urandom_range(0, 3))
                    0:       q.push_back(12'h800);
                    1:       q.push_back(12'h7FF);
                    default: q.push_back(PDW'($urandom));
                endcase
            end
            run_group("rand", mode, len, q, 1'b1);
            repeat ($urandom_range(1, 3)) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
